// File: rtl/imem_loader.sv
// imem_loader: boot loader that streams a length-prefixed program into
// instruction memory, holding the core in reset until a checksum matches.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - synchronous active-low reset
//   start      - one-cycle pulse requesting a program load
//   in_valid   - in_byte carries a valid byte
//   in_byte    - byte-stream data
//   in_ready   - loader accepts in_byte this cycle
//   imem_we    - instruction-memory write strobe
//   imem_waddr - instruction-memory write address
//   imem_wdata - instruction-memory write data
//   core_reset - active-high core reset, released only after a good load
//   load_count - instructions written in the current load
//   done       - load finished with a matching checksum
//   error      - load aborted (bad length or checksum mismatch)
module imem_loader #(
  parameter  int DEPTH  = 32,
  parameter  int INST_W = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [AW-1:0]     imem_waddr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic [CW-1:0]     load_count,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [CW-1:0]       r_len;
  logic [CW-1:0]       w_len_n;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_n;
  logic [AW-1:0]       r_addr;
  logic [AW-1:0]       w_addr_n;
  logic [INST_W-1:0]   r_word;
  logic [INST_W-1:0]   w_word_n;
  logic [7:0]          r_csum;
  logic [7:0]          w_csum_n;
  logic                w_xfer;
  logic                w_len_ok;

  assign in_ready = (r_state == S_LEN) || (r_state == S_HI) ||
                    (r_state == S_LO)  || (r_state == S_CSUM);
  assign w_xfer   = in_valid & in_ready;
  assign w_len_ok = (in_byte != 8'd0) && (int'(in_byte) <= DEPTH);

  assign imem_we    = (r_state == S_WRITE);
  assign imem_waddr = r_addr;
  assign imem_wdata = r_word;
  assign core_reset = (r_state != S_DONE);
  assign load_count = r_cnt;
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      r_csum  <= '0;
    end else begin
      r_state <= w_state_n;
      r_len   <= w_len_n;
      r_cnt   <= w_cnt_n;
      r_addr  <= w_addr_n;
      r_word  <= w_word_n;
      r_csum  <= w_csum_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_len_n   = r_len;
    w_cnt_n   = r_cnt;
    w_addr_n  = r_addr;
    w_word_n  = r_word;
    w_csum_n  = r_csum;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n = S_LEN;
          w_cnt_n   = '0;
        end
      end
      S_LEN: begin
        if (w_xfer) begin
          if (w_len_ok) begin
            w_state_n = S_HI;
            w_len_n   = CW'(in_byte);
            w_cnt_n   = '0;
            w_addr_n  = '0;
            w_csum_n  = '0;
          end else begin
            w_state_n = S_ERR;
          end
        end
      end
      S_HI: begin
        if (w_xfer) begin
          w_state_n               = S_LO;
          w_word_n[INST_W-1 -: 8] = in_byte;
          w_csum_n                = r_csum ^ in_byte;
        end
      end
      S_LO: begin
        if (w_xfer) begin
          w_state_n     = S_WRITE;
          w_word_n[7:0] = in_byte;
          w_csum_n      = r_csum ^ in_byte;
        end
      end
      S_WRITE: begin
        w_cnt_n   = r_cnt + CW'(1);
        w_addr_n  = r_addr + AW'(1);
        w_state_n = (w_cnt_n == r_len) ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (w_xfer) begin
          w_state_n = (in_byte == r_csum) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          w_state_n = S_LEN;
          w_cnt_n   = '0;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of imem_loader stream loads,
// bad lengths, checksum errors, mid-load reset and restart.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        core_reset;
  logic [5:0]  load_count;
  logic        done;
  logic        error;

  int n_tot = 0;
  int n_bad = 0;

  logic [20:0] wlog[$];
  logic [15:0] prog[$];

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_count (load_count),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) wlog.push_back({imem_waddr, imem_wdata});
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit rnd);
    bit ok;
    int k;
    ok = 1'b0;
    if (rnd) begin
      k = $urandom_range(0, 2);
      repeat (k) begin
        in_valid = 1'b0;
        in_byte  = 8'hEE;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    for (int i = 0; i < 20; i++) begin
      if (!ok) begin
        if (in_ready) ok = 1'b1;
        @(negedge clk);
      end
    end
    if (!ok) chk("send_tmo", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input logic [7:0] cs, input bit rnd);
    send(8'(prog.size()), rnd);
    foreach (prog[i]) begin
      send(prog[i][15:8], rnd);
      send(prog[i][7:0], rnd);
    end
    send(cs, rnd);
    in_valid = 1'b0;
  endtask

  logic [7:0]  cs;
  logic [7:0]  hi;
  logic [7:0]  lo;
  logic [20:0] ent;

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_rdy",  32'(in_ready),   32'd0);
    chk("rst_we",   32'(imem_we),    32'd0);
    chk("rst_addr", 32'(imem_waddr), 32'd0);
    chk("rst_data", 32'(imem_wdata), 32'd0);
    chk("rst_core", 32'(core_reset), 32'd1);
    chk("rst_cnt",  32'(load_count), 32'd0);
    chk("rst_done", 32'(done),       32'd0);
    chk("rst_err",  32'(error),      32'd0);

    reset = 1'b1;
    @(negedge clk);
    chk("idle_rdy", 32'(in_ready), 32'd0);

    // basic two-word load
    wlog.delete();
    pulse_start();
    chk("len_rdy", 32'(in_ready), 32'd1);
    pulse_start();
    chk("len_ign_rdy",  32'(in_ready),   32'd1);
    chk("len_ign_core", 32'(core_reset), 32'd1);
    prog = '{16'h1234, 16'hABCD};
    load(8'h40, 1'b0);
    chk("ok_done", 32'(done),       32'd1);
    chk("ok_err",  32'(error),      32'd0);
    chk("ok_core", 32'(core_reset), 32'd0);
    chk("ok_cnt",  32'(load_count), 32'd2);
    chk("ok_nwr",  32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("ok_w0", 32'(wlog[0]), {11'd0, 5'd0, 16'h1234});
      chk("ok_w1", 32'(wlog[1]), {11'd0, 5'd1, 16'hABCD});
    end

    // restart from DONE, bad checksum
    wlog.delete();
    pulse_start();
    chk("rs_core", 32'(core_reset), 32'd1);
    chk("rs_rdy",  32'(in_ready),   32'd1);
    chk("rs_done", 32'(done),       32'd0);
    chk("rs_cnt",  32'(load_count), 32'd0);
    load(8'h41, 1'b0);
    chk("bad_err",  32'(error),      32'd1);
    chk("bad_done", 32'(done),       32'd0);
    chk("bad_core", 32'(core_reset), 32'd1);
    chk("bad_nwr",  32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("bad_w0", 32'(wlog[0]), {11'd0, 5'd0, 16'h1234});
      chk("bad_w1", 32'(wlog[1]), {11'd0, 5'd1, 16'hABCD});
    end

    // illegal lengths
    wlog.delete();
    pulse_start();
    chk("l0_clr", 32'(error), 32'd0);
    send(8'h00, 1'b0);
    in_valid = 1'b0;
    chk("l0_err", 32'(error), 32'd1);
    pulse_start();
    send(8'h21, 1'b0);
    in_valid = 1'b0;
    chk("l33_err", 32'(error), 32'd1);
    @(negedge clk);
    chk("lbad_nwr", 32'(wlog.size()), 32'd0);

    // reset after high byte of instruction 3
    wlog.delete();
    pulse_start();
    send(8'h04, 1'b0);
    send(8'h11, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    chk("mr_rdy",  32'(in_ready),   32'd0);
    chk("mr_we",   32'(imem_we),    32'd0);
    chk("mr_addr", 32'(imem_waddr), 32'd0);
    chk("mr_data", 32'(imem_wdata), 32'd0);
    chk("mr_core", 32'(core_reset), 32'd1);
    chk("mr_cnt",  32'(load_count), 32'd0);
    chk("mr_done", 32'(done),       32'd0);
    chk("mr_err",  32'(error),      32'd0);
    chk("mr_nwr",  32'(wlog.size()), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    wlog.delete();
    pulse_start();
    prog = '{16'h5AA5};
    load(8'hFF, 1'b0);
    chk("ml_done", 32'(done),       32'd1);
    chk("ml_cnt",  32'(load_count), 32'd1);
    chk("ml_nwr",  32'(wlog.size()), 32'd1);
    if (wlog.size() == 1)
      chk("ml_w0", 32'(wlog[0]), {11'd0, 5'd0, 16'h5AA5});

    // full 32-word load, random gaps, start held early in the load
    wlog.delete();
    pulse_start();
    send(8'd32, 1'b1);
    cs = 8'h00;
    for (int i = 0; i < 32; i++) begin
      hi = 8'h80 | 8'(i);
      lo = 8'(i * 7 + 3);
      cs = cs ^ hi ^ lo;
      if (i == 0) start = 1'b1;
      send(hi, 1'b1);
      send(lo, 1'b1);
      if (i == 1) start = 1'b0;
    end
    start = 1'b0;
    send(cs, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("f_done", 32'(done),       32'd1);
    chk("f_cnt",  32'(load_count), 32'd32);
    chk("f_nwr",  32'(wlog.size()), 32'd32);
    if (wlog.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        ent = {5'(i), 8'h80 | 8'(i), 8'(i * 7 + 3)};
        chk($sformatf("f_w%0d", i), 32'(wlog[i]), 32'(ent));
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 32, is the number of instruction-memory words, fixing the 5-bit write address.
REQ-002 Parameter INST_W, default 16, is the instruction width in bits, assembled from two bytes.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the rising clk edge).
REQ-005 start  input  1  one-cycle pulse that requests a program load.
REQ-006 in_valid  input  1  in_byte holds a valid byte.
REQ-007 in_byte  input  8  byte-stream data.
REQ-008 in_ready  output  1  loader accepts in_byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_waddr  output  5  instruction-memory write address.
REQ-011 imem_wdata  output  16  instruction-memory write data.
REQ-012 core_reset  output  1  active-high reset to the processor core; it holds the core in reset while loading.
REQ-013 load_count  output  6  number of instructions written in the current load.
REQ-014 done  output  1  load completed with a matching checksum.
REQ-015 error  output  1  load aborted (bad length or checksum mismatch).

Function
REQ-016 Byte transfer occurs only on a cycle where in_valid=1 and in_ready=1; no other cycle consumes a byte.
REQ-017 Stream format: length byte N, then N instructions as high byte then low byte, then one checksum byte.
REQ-018 FSM states: IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR.
REQ-019 in_ready=1 only in LEN, HI, LO and CSUM; in_ready=0 in IDLE, WRITE, DONE and ERR.
REQ-020 IDLE -> LEN on start=1; in LEN, HI, LO, CSUM and WRITE, start is ignored.
REQ-021 LEN, on a byte transfer: N in 1..32 -> HI, with count and address cleared to 0 and checksum cleared to 0; N=0 or N>32 -> ERR.
REQ-022 HI, on a byte transfer: the byte is latched as imem_wdata[15:8] -> LO; LO, on a byte transfer: the byte is latched as imem_wdata[7:0] -> WRITE.
REQ-023 Every HI and LO byte is XORed into the running checksum; the length byte and checksum byte are excluded.
REQ-024 WRITE lasts exactly one cycle with imem_we=1, imem_waddr = current address, and imem_wdata = the assembled word.
REQ-025 On leaving WRITE, address and load_count increment by 1; if load_count then equals N the FSM goes to CSUM, else to HI.
REQ-026 imem_we SHALL be 0 in every state except WRITE.
REQ-027 No address wrap: with N<=32 the final write uses address N-1 <= 31; load_count reaches at most 32.
REQ-028 CSUM, on a byte transfer: byte equals the running checksum -> DONE, else -> ERR.
REQ-029 done=1 exactly while in DONE, and error=1 exactly while in ERR; both are registered state decodes.
REQ-030 core_reset=1 in every state except DONE; in DONE core_reset=0, which releases the core.
REQ-031 DONE or ERR, with start=1 -> LEN: done and error clear, core_reset=1, load_count cleared to 0.
REQ-032 Instruction memory contents are never cleared by the loader; an aborted load leaves the words already written in place.

Reset
REQ-033 reset=0 at a rising edge forces IDLE from any state, including mid-load, and overrides start and any byte transfer in that cycle.
REQ-034 Reset values: in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, core_reset=1, load_count=0, done=0, error=0, checksum=0.

Verification
REQ-035 Stream start, then bytes 02,12,34,AB,CD,checksum 40 with in_valid always 1 -> writes {0:1234},{1:ABCD}; imem_we high exactly 2 cycles; done=1; core_reset=0; load_count=2.
REQ-036 Same stream with checksum byte 41 -> error=1, done=0, core_reset stays 1, both words still written.
REQ-037 Length byte 00, and separately 21 -> ERR immediately after the length byte, with no imem_we pulse.
REQ-038 N=32 with in_valid toggling randomly -> 32 writes to addresses 0..31 in order, no extra write, done=1, load_count=32.
REQ-039 reset=0 asserted after the high byte of instruction 3 -> next cycle IDLE with all outputs at reset values; a subsequent start and full stream loads correctly.
REQ-040 Check from DONE: start pulse -> core_reset returns to 1 and in_ready=1 the next cycle. Check from IDLE: start asserted during LEN is ignored.
